load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's execute stage and the word-addressed, byte-enabled data memory, which samples address/write data on the clock edge and returns read data registered one cycle later. Accepts one byte/half/word load or store per request over a valid/ready handshake and drives the memory's word address, lane write enables and lane-shifted write data. Splits misaligned accesses into two word accesses and returns the merged, sign- or zero-extended load result as a single-cycle response pulse.

## Interface
- SUPPORT_MISALIGNED, default 1: 1 = split word-crossing accesses into two memory cycles; 0 = reject them with an error.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept; 0 while reset is high.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_address  input  32 (addr_t)  byte address.
- req_wdata  input  32 (data_t)  store data, right-justified.
- resp_valid  output  1  one-cycle response pulse; no backpressure.
- resp_rdata  output  32 (data_t)  load result; 0 for stores and errors.
- resp_error  output  1  qualified by resp_valid: illegal size or rejected misalignment.
- mem_address  output  32 (addr_t)  word-aligned; bits [1:0] always 00.
- mem_write_data  output  32 (data_t)  lane-shifted store data.
- mem_write_enable  output  4  per-byte lane enables.
- mem_read_data  input  32 (data_t)  memory read data; reflects the address presented in the previous cycle.

## Operation
- States: IDLE, LO, HI, WAIT. Reset → IDLE.
- IDLE: req_ready=1, mem_write_enable=0. On req_valid: latch the request and off=addr[1:0], then go to LO.
- split = (half && off==3) || (word && off!=0). If split && !SUPPORT_MISALIGNED, or if size==11, then err=1: LO drives enables 0, no memory change.
- LO: mem_address={addr[31:2],00}; next state is HI if split && !err, else WAIT.
- HI: mem_address={addr[31:2],00}+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). Capture mem_read_data (the LO word) into lo_buf. Next state is WAIT.
- WAIT: mem_read_data is the last word accessed. Register the result, pulse resp_valid next cycle, go to IDLE.
- Lane enables: base mask is 0001 (byte), 0011 (half), 1111 (word).
  - LO enable = (base<<off)[3:0].
  - HI enable = (base<<off)[7:4].
  - Stores only; loads drive 0000.
- Write data: LO = req_wdata<<8·off; HI = req_wdata>>8·(4−off). Unused lanes don't-care.
- Load merge: w = split ? {HI word, lo_buf} : {0, LO word}. r = w>>8·off. Take r[7:0] or r[15:0] (or r[31:0] for word), then extend per req_unsigned. For word loads, req_unsigned is ignored.
- Stores: resp_rdata=0, resp_error=err.
- Reset mid-operation: return to IDLE immediately, enables 0, resp_valid 0, no response. A split store interrupted after LO leaves its LO half committed. This is accepted behaviour.

## Timing
- Reset values: req_ready=0 while reset asserted, 1 after release; resp_valid=0, resp_rdata=0, resp_error=0, mem_write_enable=0, mem_address=0, mem_write_data=0.
- Latency from the accept edge (cycle 0) to resp_valid:
  - Aligned or error: LO in cycle 1, WAIT in cycle 2, resp_valid high in cycle 3.
  - Split: one extra cycle, resp_valid high in cycle 4.
- resp_valid coincides with IDLE. A new request may be accepted in the same cycle as resp_valid, giving back-to-back throughput of 1 request per 3 cycles (aligned).
- resp_rdata and resp_error hold their values until the next response.
- mem_* outputs are functions of state and latched request only. They never depend combinationally on req_*.

## Test plan
- Preload 0x100=0x8899AABB. Byte load at 0x103, signed → resp_rdata=0xFFFFFF88 in cycle 3. Same access unsigned → 0x00000088.
- Store half 0x1234 at 0x102 → single LO access: enables 1100, write_data[31:16]=0x1234. Word at 0x100 becomes 0x1234AABB.
- Preload 0x100=0x44332211, 0x104=0x88776655. Word load at 0x101 → LO then HI (address 0x104), resp_rdata=0x55443322 in cycle 4. Word store 0xDEADBEEF at 0x103 → LO enable 1000, HI enable 0111; memory becomes 0x100=0xEF332211, 0x104=0x88DEADBE.
- SUPPORT_MISALIGNED=0: word load at 0x102 → no memory write, resp_error=1, resp_rdata=0 in cycle 3. Any req_size=11 → same result.
- Word load at 0xFFFFFFFE (split) → HI mem_address=0x00000000.
- Assert reset during HI of a split store → next cycle IDLE, enables 0, no resp_valid; 0x104 unmodified. A request after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-addressed, byte-enabled memory.
// Word-crossing accesses are split into a LO and a HI word access and merged on return.
module load_store_unit #(
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, LO, HI, WAIT} state_t;

    state_t      state, state_next;
    logic        op_write, op_unsigned, op_two, op_error;
    logic [1:0]  op_size, off;
    logic [31:0] op_address, op_wdata, lo_buf, load_value, aligned;
    logic [63:0] merged;
    logic [3:0]  base_mask;
    logic [7:0]  lane_span;
    logic        req_split, req_error, store_ok;

    assign off      = op_address[1:0];
    assign store_ok = op_write && !op_error;

    always_comb begin
        req_split = ((req_size == 2'b01) && (req_address[1:0] == 2'b11)) ||
                    ((req_size == 2'b10) && (req_address[1:0] != 2'b00));
        req_error = (req_size == 2'b11) || (req_split && !SUPPORT_MISALIGNED);
    end

    assign req_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_write    <= 1'b0;
            op_unsigned <= 1'b0;
            op_two      <= 1'b0;
            op_error    <= 1'b0;
            op_size     <= '0;
            op_address  <= '0;
            op_wdata    <= '0;
        end else if (state == IDLE && req_valid) begin
            op_write    <= req_write;
            op_unsigned <= req_unsigned;
            op_two      <= req_split && !req_error;
            op_error    <= req_error;
            op_size     <= req_size;
            op_address  <= req_address;
            op_wdata    <= req_wdata;
        end
    end

    // In HI the memory is returning the LO word accessed one cycle earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_buf <= '0;
        end else if (state == HI) begin
            lo_buf <= mem_read_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = LO;
            LO:   state_next = op_two ? HI : WAIT;
            HI:   state_next = WAIT;
            WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (op_size)
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            2'b10:   base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
        lane_span = {4'b0000, base_mask} << off;
    end

    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = '0;
        case (state)
            LO: begin
                mem_address      = {op_address[31:2], 2'b00};
                mem_write_data   = op_wdata << {off, 3'b000};
                mem_write_enable = store_ok ? lane_span[3:0] : 4'b0000;
            end
            HI: begin
                mem_address      = {op_address[31:2], 2'b00} + 32'd4;
                mem_write_data   = op_wdata >> (6'd32 - {1'b0, off, 3'b000});
                mem_write_enable = store_ok ? lane_span[7:4] : 4'b0000;
            end
            default: ;
        endcase
    end

    always_comb begin
        merged  = op_two ? {mem_read_data, lo_buf} : {32'b0, mem_read_data};
        aligned = 32'(merged >> {off, 3'b000});
        case (op_size)
            2'b00:   load_value = op_unsigned ? {24'b0, aligned[7:0]}
                                              : {{24{aligned[7]}}, aligned[7:0]};
            2'b01:   load_value = op_unsigned ? {16'b0, aligned[15:0]}
                                              : {{16{aligned[15]}}, aligned[15:0]};
            default: load_value = aligned;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            resp_valid <= (state == WAIT);
            if (state == WAIT) begin
                resp_error <= op_error;
                resp_rdata <= (op_write || op_error) ? 32'b0 : load_value;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_write_enable;

    logic        nm_req_valid, nm_req_ready, nm_resp_valid, nm_resp_error;
    logic [31:0] nm_resp_rdata, nm_mem_address, nm_mem_write_data;
    logic [3:0]  nm_mem_write_enable;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.SUPPORT_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    load_store_unit #(.SUPPORT_MISALIGNED(1'b0)) dut_nm (
        .clk(clk), .reset(reset),
        .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(nm_resp_valid), .resp_rdata(nm_resp_rdata),
        .resp_error(nm_resp_error), .mem_address(nm_mem_address),
        .mem_write_data(nm_mem_write_data), .mem_write_enable(nm_mem_write_enable),
        .mem_read_data(32'hA5A5A5A5)
    );

    // Data memory seen by the main DUT: 256 words, aliased on address bits [9:2].
    logic [31:0] mem [256];
    logic [31:0] mem_word;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        mem_read_data <= mem[mem_address[9:2]];
        if (mem_write_enable != 4'b0000) begin
            mem_word = mem[mem_address[9:2]];
            for (int i = 0; i < 4; i++)
                if (mem_write_enable[i]) mem_word[8*i +: 8] = mem_write_data[8*i +: 8];
            mem[mem_address[9:2]] <= mem_word;
        end
        if (bd_we) mem[bd_idx] <= bd_data;
    end

    logic [7:0] ref_mem [1024];

    function automatic logic [31:0] ref_word(input logic [7:0] idx);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[{idx, 2'(i)}];
        return r;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = a[9:2]; bd_data = d;
        for (int i = 0; i < 4; i++) ref_mem[{a[9:2], 2'(i)}] = d[8*i +: 8];
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Reference: access bytes a..a+n-1 one at a time, then extend.
    task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit misal_ok,
                         output logic [31:0] e_rd, output logic e_err, output int e_lat,
                         output logic [3:0] e_en1, output logic [3:0] e_en2,
                         output logic [31:0] e_ad1, output logic [31:0] e_ad2);
        int n, off, lane;
        logic [31:0] v;
        logic [9:0] bi;
        n = 1 << sz;
        off = int'(a[1:0]);
        e_err = (sz == 2'b11) || ((off + n > 4) && !misal_ok);
        e_lat = (!e_err && off + n > 4) ? 4 : 3;
        e_ad1 = a & 32'hFFFF_FFFC;
        e_ad2 = e_ad1 + 32'd4;
        e_en1 = '0; e_en2 = '0; e_rd = '0; v = '0;
        if (!e_err) begin
            for (int i = 0; i < n; i++) begin
                bi = a[9:0] + 10'(i);
                lane = off + i;
                if (wr) begin
                    ref_mem[bi] = wd[8*i +: 8];
                    if (lane < 4) e_en1[lane] = 1'b1;
                    else e_en2[lane - 4] = 1'b1;
                end else begin
                    v[8*i +: 8] = ref_mem[bi];
                end
            end
            if (!wr) begin
                if (n < 4 && !uns && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8*n));
                e_rd = v;
            end
        end
    endtask

    task automatic issue(input bit use_nm, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic [3:0] en1, output logic [3:0] en2,
                         output logic [31:0] ad1, output logic [31:0] ad2, output logic any_en);
        int guard;
        bit got;
        logic [3:0] cur_en;
        logic [31:0] cur_ad;
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns; req_address = a; req_wdata = wd;
        guard = 0;
        while (!(use_nm ? nm_req_ready : req_ready) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL handshake: req_ready stuck low got 0 expected 1");
        end
        if (use_nm) nm_req_valid = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; nm_req_valid = 1'b0;
        lat = 1; got = 1'b0; any_en = 1'b0;
        rd = '0; er = 1'b0; en1 = '0; en2 = '0; ad1 = '0; ad2 = '0;
        while (!got && lat < 10) begin
            cur_en = use_nm ? nm_mem_write_enable : mem_write_enable;
            cur_ad = use_nm ? nm_mem_address : mem_address;
            any_en = any_en | (cur_en != 4'b0000);
            if (lat == 1) begin en1 = cur_en; ad1 = cur_ad; end
            if (lat == 2) begin en2 = cur_en; ad2 = cur_ad; end
            if (use_nm ? nm_resp_valid : resp_valid) begin
                got = 1'b1;
                rd = use_nm ? nm_resp_rdata : resp_rdata;
                er = use_nm ? nm_resp_error : resp_error;
            end else begin
                @(posedge clk);
                #1 lat++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout: no resp_valid got %0d cycles expected <10", lat);
        end
    endtask

    logic [31:0] rd, ad1, ad2, e_rd, e_ad1, e_ad2;
    logic        er, any_en, e_err;
    logic [3:0]  en1, en2, e_en1, e_en2;
    int          lat, e_lat;

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; nm_req_valid = 1'b0; req_write = 1'b0;
        req_size = '0; req_unsigned = 1'b0; req_address = '0; req_wdata = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", resp_rdata); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", resp_error); end
        checks++; if (mem_write_enable !== 4'h0) begin errors++; $display("FAIL rst_we: got %b expected 0000", mem_write_enable); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_address); end
        checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", mem_write_data); end
        @(negedge clk) reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
        checks++; if (nm_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_nm_ready: got %b expected 1", nm_req_ready); end
    endtask

    task automatic test_byte_load();
        preload(32'h100, 32'h8899AABB);
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (rd !== 32'hFFFFFF88) begin errors++; $display("FAIL lb_signed: got %h expected ffffff88", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", lat); end
        checks++; if (ad1 !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h expected 00000100", ad1); end
        checks++; if (any_en !== 1'b0) begin errors++; $display("FAIL lb_no_write: got %b expected 0", any_en); end
        issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (rd !== 32'h00000088) begin errors++; $display("FAIL lb_unsigned: got %h expected 00000088", rd); end
    endtask

    task automatic test_half_store();
        model(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234, 1'b1, e_rd, e_err, e_lat, e_en1, e_en2, e_ad1, e_ad2);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_address = 32'h102; req_wdata = 32'h1234;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++; if (mem_write_enable !== 4'b1100) begin errors++; $display("FAIL sh_enable: got %b expected 1100", mem_write_enable); end
        checks++; if (mem_write_data[31:16] !== 16'h1234) begin errors++; $display("FAIL sh_wdata: got %h expected 1234", mem_write_data[31:16]); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
            errors++; $display("FAIL sh_resp: got v=%b d=%h e=%b expected v=1 d=0 e=0", resp_valid, resp_rdata, resp_error);
        end
        checks++; if (mem[8'h40] !== 32'h1234AABB) begin errors++; $display("FAIL sh_mem: got %h expected 1234aabb", mem[8'h40]); end
    endtask

    task automatic test_split();
        preload(32'h100, 32'h44332211);
        preload(32'h104, 32'h88776655);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (rd !== 32'h55443322) begin errors++; $display("FAIL lw_split_data: got %h expected 55443322", rd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL lw_split_latency: got %0d expected 4", lat); end
        checks++; if (ad2 !== 32'h104) begin errors++; $display("FAIL lw_split_hi_addr: got %h expected 00000104", ad2); end
        model(1'b1, 2'b10, 1'b0, 32'h103, 32'hDEADBEEF, 1'b1, e_rd, e_err, e_lat, e_en1, e_en2, e_ad1, e_ad2);
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h103, 32'hDEADBEEF, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (en1 !== 4'b1000 || en2 !== 4'b0111) begin errors++; $display("FAIL sw_split_enables: got %b/%b expected 1000/0111", en1, en2); end
        checks++; if (mem[8'h40] !== 32'hEF332211) begin errors++; $display("FAIL sw_split_lo: got %h expected ef332211", mem[8'h40]); end
        checks++; if (mem[8'h41] !== 32'h88DEADBE) begin errors++; $display("FAIL sw_split_hi: got %h expected 88deadbe", mem[8'h41]); end
    endtask

    task automatic test_errors();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 3 || any_en !== 1'b0) begin
            errors++; $display("FAIL nm_misaligned: got e=%b d=%h lat=%0d wr=%b expected e=1 d=0 lat=3 wr=0", er, rd, lat, any_en);
        end
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h101, 32'h11111111, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (er !== 1'b1 || any_en !== 1'b0) begin errors++; $display("FAIL nm_misaligned_store: got e=%b wr=%b expected e=1 wr=0", er, any_en); end
        issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h104, 32'h22222222, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 3 || any_en !== 1'b0) begin
            errors++; $display("FAIL nm_size11: got e=%b d=%h lat=%0d wr=%b expected e=1 d=0 lat=3 wr=0", er, rd, lat, any_en);
        end
        issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h108, 32'h0, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (er !== 1'b0 || rd !== 32'hA5A5A5A5 || lat !== 3) begin
            errors++; $display("FAIL nm_aligned: got e=%b d=%h lat=%0d expected e=0 d=a5a5a5a5 lat=3", er, rd, lat);
        end
        issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h100, 32'h33333333, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 3 || any_en !== 1'b0) begin
            errors++; $display("FAIL size11_store: got e=%b d=%h lat=%0d wr=%b expected e=1 d=0 lat=3 wr=0", er, rd, lat, any_en);
        end
        checks++; if (mem[8'h40] !== ref_word(8'h40)) begin errors++; $display("FAIL size11_mem: got %h expected %h", mem[8'h40], ref_word(8'h40)); end
    endtask

    task automatic test_wrap();
        preload(32'hFFFFFFFC, 32'h11223344);
        preload(32'h00000000, 32'h55667788);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (ad1 !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_lo_addr: got %h expected fffffffc", ad1); end
        checks++; if (ad2 !== 32'h00000000) begin errors++; $display("FAIL wrap_hi_addr: got %h expected 00000000", ad2); end
        checks++; if (rd !== 32'h77881122 || lat !== 4) begin errors++; $display("FAIL wrap_data: got %h lat=%0d expected 77881122 lat=4", rd, lat); end
    endtask

    task automatic test_random();
        logic wr, uns;
        logic [1:0] sz;
        logic [31:0] a, wd;
        int pick;
        for (int w = 32'h100; w < 32'h300; w += 4) preload(32'(w), $urandom);
        for (int k = 0; k < 60; k++) begin
            wr = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            sz = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
            a = 32'h100 + 32'($urandom_range(0, 32'h1F8));
            wd = $urandom;
            model(wr, sz, uns, a, wd, 1'b1, e_rd, e_err, e_lat, e_en1, e_en2, e_ad1, e_ad2);
            issue(1'b0, wr, sz, uns, a, wd, rd, er, lat, en1, en2, ad1, ad2, any_en);
            checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd_rdata[%0d] a=%h sz=%0d: got %h expected %h", k, a, sz, rd, e_rd); end
            checks++; if (er !== e_err) begin errors++; $display("FAIL rnd_error[%0d]: got %b expected %b", k, er, e_err); end
            checks++; if (lat !== e_lat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", k, lat, e_lat); end
            checks++; if (en1 !== e_en1 || en2 !== e_en2) begin errors++; $display("FAIL rnd_enables[%0d]: got %b/%b expected %b/%b", k, en1, en2, e_en1, e_en2); end
            checks++; if (ad1 !== e_ad1) begin errors++; $display("FAIL rnd_lo_addr[%0d]: got %h expected %h", k, ad1, e_ad1); end
            if (e_lat == 4) begin
                checks++; if (ad2 !== e_ad2) begin errors++; $display("FAIL rnd_hi_addr[%0d]: got %h expected %h", k, ad2, e_ad2); end
            end
            if (wr) begin
                checks++; if (mem[e_ad1[9:2]] !== ref_word(e_ad1[9:2]) || mem[e_ad2[9:2]] !== ref_word(e_ad2[9:2])) begin
                    errors++; $display("FAIL rnd_mem[%0d]: got %h %h expected %h %h", k, mem[e_ad1[9:2]], mem[e_ad2[9:2]], ref_word(e_ad1[9:2]), ref_word(e_ad2[9:2]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        preload(32'h200, 32'hCAFEF00D);
        preload(32'h204, 32'h0BADBEEF);
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_address = 32'h200; req_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", req_ready); end
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'((c == 3) || (c == 6))) begin errors++; $display("FAIL b2b_valid[c%0d]: got %b expected %b", c, resp_valid, (c == 3) || (c == 6)); end
            if (c == 3) begin
                checks++; if (resp_rdata !== 32'hCAFEF00D || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h ready=%b expected cafef00d ready=1", resp_rdata, req_ready); end
                req_address = 32'h204;
            end
            if (c == 6) begin
                checks++; if (resp_rdata !== 32'h0BADBEEF) begin errors++; $display("FAIL b2b_second: got %h expected 0badbeef", resp_rdata); end
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        preload(32'h100, 32'h44332211);
        preload(32'h104, 32'h88776655);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_address = 32'h103; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (mem_write_enable !== 4'b0111) begin errors++; $display("FAIL rmo_in_hi: got %b expected 0111", mem_write_enable); end
        reset = 1'b1;
        #1;
        checks++; if (mem_write_enable !== 4'b0000 || req_ready !== 1'b0) begin errors++; $display("FAIL rmo_async: got we=%b ready=%b expected we=0000 ready=0", mem_write_enable, req_ready); end
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        ref_mem[10'h103] = 8'hEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rmo_no_resp[%0d]: got %b expected 0", c, resp_valid); end
        end
        checks++; if (mem[8'h41] !== 32'h88776655) begin errors++; $display("FAIL rmo_hi_untouched: got %h expected 88776655", mem[8'h41]); end
        checks++; if (mem[8'h40] !== 32'hEF332211) begin errors++; $display("FAIL rmo_lo_committed: got %h expected ef332211", mem[8'h40]); end
        model(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, e_rd, e_err, e_lat, e_en1, e_en2, e_ad1, e_ad2);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, rd, er, lat, en1, en2, ad1, ad2, any_en);
        checks++; if (rd !== e_rd || er !== 1'b0 || lat !== 4) begin errors++; $display("FAIL rmo_after: got %h e=%b lat=%0d expected %h e=0 lat=4", rd, er, lat, e_rd); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_byte_load();
        test_half_store();
        test_split();
        test_errors();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded got 2000000 expected less");
        $fatal(1);
    end
endmodule
